// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional busy-rise watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic [DATA_BITS-1:0]           o_tx_data,
  output logic                           o_tx_start,
  input  logic                           i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
  output logic                           o_active
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                           o_tx_timeout
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [DATA_BITS-1:0]  r_tx_data;

  logic                  w_found;
  logic [ID_W-1:0]       w_winner;
  logic [ID_W-1:0]       w_cand;
  logic [DATA_BITS-1:0]  w_word;
  logic                  w_accept;

  // Search starts just after the last winner and wraps with an explicit modulo,
  // so non-power-of-2 requester counts rotate correctly.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_word = i_req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign w_accept = (r_state == IDLE) && !i_tx_busy && w_found;

  always_comb begin
    o_req_ready = '0;
    if (w_accept) begin
      o_req_ready[w_winner] = 1'b1;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_tx_timeout;
  logic            w_timeout_fire;

  // Counter is held at zero outside WAIT_BUSY, so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt     <= '0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_tx_timeout <= w_timeout_fire;
      if (r_state == WAIT_BUSY) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_tx_timeout = r_tx_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (BUSY_TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_tx_start   = 1'b0;
    o_active     = (r_state != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    w_timeout_fire = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        o_tx_start   = 1'b1;
        w_next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_next_state = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
          w_timeout_fire = 1'b1;
          w_next_state   = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Word, owner and last-winner pointer only change on an accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
    end else if (w_accept) begin
      r_rr_ptr   <= w_winner;
      r_grant_id <= w_winner;
      r_tx_data  <= w_word;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_grant_id = r_grant_id;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. It accepts one word from the winning requester over a valid/ready handshake and holds it in a register. It then launches the word with a one-cycle tx_start pulse and owns the transmitter until tx_busy deasserts. It sits between the client logic and uart_tx.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_BITS, 8, UART word width (matches uart_tx DATA_BITS)
BUSY_TIMEOUT, 16, clk cycles allowed for tx_busy to rise after tx_start (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  bit i: requester i has a word
req_data  in  NUM_REQ*DATA_BITS  word of requester i at [i*DATA_BITS +: DATA_BITS]
req_ready  out  NUM_REQ  one-hot accept; word i is transferred when req_valid[i] and req_ready[i] are both high
tx_data  out  DATA_BITS  word presented to the transmitter
tx_start  out  1  one-cycle launch pulse to the transmitter
tx_busy  in  1  transmitter busy, high for the duration of a frame
grant_id  out  $clog2(NUM_REQ)  index of the requester that owns the current or last transfer
active  out  1  high whenever state != IDLE
tx_timeout  out  1  one-cycle error pulse (present only with UART_ARB_TIMEOUT_EN)

Behaviour:
- Reset values: state IDLE; tx_start 0; tx_data 0; grant_id 0; active 0; req_ready 0; rr_ptr (last winner) NUM_REQ-1, so requester 0 has first priority; tx_timeout 0.
- Reset mid-transfer: the latched word is abandoned and no retry is made. tx_start is 0 from the cycle after reset onward.
- State machine has four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ.
  - req_ready[winner] is driven combinationally, and only when state=IDLE, tx_busy=0 and any req_valid is high. All other bits of req_ready are 0.
  - On that edge: tx_data <= word of winner, grant_id <= winner, rr_ptr <= winner, state -> LAUNCH.
  - If tx_busy=1 or no request is pending, the block stays in IDLE and req_ready is all zeros.
- LAUNCH: tx_start=1 for exactly this cycle, then state -> WAIT_BUSY.
- WAIT_BUSY: stays until tx_busy=1, then -> WAIT_DONE. The block does not re-pulse tx_start.
- WAIT_DONE: stays until tx_busy=0, then -> IDLE. A new grant is possible in the following cycle.
- Latency: from the accept edge, tx_start is high in the next cycle. Minimum spacing between two accepts = frame time + 3 cycles.
- tx_data and grant_id are held constant from accept until the next accept.
- Fairness: a requester holding req_valid continuously is served at least once every NUM_REQ grants.
- A requester deasserting req_valid before it is granted is legal; it is simply skipped.
- Width rule: rr_ptr wrap uses explicit modulo NUM_REQ, so non-power-of-2 NUM_REQ is supported.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_BUSY.
  - If tx_busy has not risen after BUSY_TIMEOUT cycles, the block pulses tx_timeout for 1 cycle and returns to IDLE.
  - The word is dropped and rr_ptr keeps the winner's index.
  - The counter clears on every entry to WAIT_BUSY.
- Undefined: the tx_timeout port and the counter are absent, and WAIT_BUSY waits indefinitely.

Test Plan:
- Reset, then req_valid=4'b0001 with word 0x41 -> req_ready=0001 in the same cycle; tx_start high 1 cycle later with tx_data=0x41 and grant_id=0; model busy for 10 cycles -> returns to IDLE.
- All four req_valid held high with words 0x10..0x13 -> grant order 0,1,2,3,0; each tx_data matches its requester's word.
- rr_ptr=1 with req_valid=4'b1001 -> requester 3 granted before requester 0.
- tx_busy held high while in IDLE with a request pending -> req_ready stays 0; grant occurs the cycle after tx_busy falls.
- Reset asserted during WAIT_DONE -> next cycle active=0, tx_start=0 and grant_id=0; requester 0 is granted first afterwards.
- With UART_ARB_TIMEOUT_EN and BUSY_TIMEOUT=16, tx_busy never rises -> tx_timeout pulses 16 cycles after entering WAIT_BUSY, then the next requester is served.
